// File: rtl/ram_bank_arbiter_if.sv
// Requester-side bus of the RAM bank arbiter: single-word requests in,
// per-requester grant and read response out.
interface ram_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int RAM_NUM = 10,
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 10,
    parameter int BANK_W  = $clog2(RAM_NUM)
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_we;
    logic [NUM_REQ-1:0][BANK_W-1:0]  req_bank;
    logic [NUM_REQ-1:0][ADDRESS-1:0] req_addr;
    logic [NUM_REQ-1:0][WIDTH-1:0]   req_wdata;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_bank_arbiter.sv
// Round-robin arbiter sharing port A of a multi-bank RAM among several
// requesters. Each bank arbitrates independently with its own pointer;
// grants are combinational and read data returns one cycle after grant.
module ram_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int RAM_NUM = 10,
    parameter int WIDTH   = 16,
    parameter int ADDRESS = 10,
    parameter int BANK_W  = $clog2(RAM_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    ram_bank_arbiter_if.slave                bus,
    output logic [RAM_NUM-1:0]               ram_en,
    output logic [RAM_NUM-1:0]               ram_we,
    output logic [RAM_NUM-1:0][ADDRESS-1:0]  ram_addr,
    output logic [RAM_NUM-1:0][WIDTH-1:0]    ram_din,
    input  logic [RAM_NUM-1:0][WIDTH-1:0]    ram_dout,
    output logic                             err_bank,
    output logic [15:0]                      stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RAM_NUM-1:0][PTR_W-1:0]  rr_ptr;
    logic [RAM_NUM-1:0]             bank_grant;
    logic [RAM_NUM-1:0][PTR_W-1:0]  bank_win;
    logic [NUM_REQ-1:0]             oob;
    logic [NUM_REQ-1:0]             ready;
    logic [NUM_REQ-1:0]             pend;
    logic [NUM_REQ-1:0]             pend_bad;
    logic [NUM_REQ-1:0][BANK_W-1:0] pend_bank;
    logic [NUM_REQ-1:0][WIDTH-1:0]  rsp_data;

    // Flag requests whose bank index lies beyond the last physical bank
    always_comb begin
        oob = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            oob[r] = ({1'b0, bus.req_bank[r]} >= (BANK_W+1)'(RAM_NUM));
        end
    end

    // Per-bank round-robin pick from the bank pointer upward, then drive RAM port A
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        sum        = '0;
        idx        = '0;
        bank_grant = '0;
        bank_win   = '0;
        ready      = '0;
        ram_en     = '0;
        ram_we     = '0;
        ram_addr   = '0;
        ram_din    = '0;
        if (rst) begin
            for (int b = 0; b < RAM_NUM; b++) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    sum = {1'b0, rr_ptr[b]} + (PTR_W+1)'(k);
                    if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                        sum = sum - (PTR_W+1)'(NUM_REQ);
                    end
                    idx = sum[PTR_W-1:0];
                    if (!bank_grant[b] && bus.req_valid[idx] &&
                        bus.req_bank[idx] == BANK_W'(b)) begin
                        bank_grant[b] = 1'b1;
                        bank_win[b]   = idx;
                    end
                end
            end
            for (int b = 0; b < RAM_NUM; b++) begin
                if (bank_grant[b]) begin
                    ready[bank_win[b]] = 1'b1;
                    ram_en[b]          = 1'b1;
                    ram_we[b]          = bus.req_we[bank_win[b]];
                    ram_addr[b]        = bus.req_addr[bank_win[b]];
                    ram_din[b]         = bus.req_wdata[bank_win[b]];
                end
            end
            // A bad bank index never touches the RAM, so it is accepted at once
            for (int r = 0; r < NUM_REQ; r++) begin
                if (bus.req_valid[r] && oob[r]) begin
                    ready[r] = 1'b1;
                end
            end
        end
    end

    // Advance each bank's pointer past its winner, only on cycles it grants
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else begin
            for (int b = 0; b < RAM_NUM; b++) begin
                if (bank_grant[b]) begin
                    rr_ptr[b] <= (bank_win[b] == PTR_W'(NUM_REQ - 1)) ? '0
                                                                       : bank_win[b] + 1'b1;
                end
            end
        end
    end

    // Remember granted reads so the RAM output can be steered back next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= '0;
            pend_bad  <= '0;
            pend_bank <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                pend[r]      <= bus.req_valid[r] & ready[r] & ~bus.req_we[r];
                pend_bad[r]  <= oob[r];
                pend_bank[r] <= bus.req_bank[r];
            end
        end
    end

    // Route the registered RAM output of the pending bank; bad-bank reads return zero
    always_comb begin
        rsp_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int b = 0; b < RAM_NUM; b++) begin
                if (pend[r] && !pend_bad[r] && pend_bank[r] == BANK_W'(b)) begin
                    rsp_data[r] = ram_dout[b];
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = pend;
    assign bus.rsp_data  = rsp_data;

    // Sticky bad-bank flag and saturating count of cycles where someone waits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_bank  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (|(bus.req_valid & oob)) begin
                err_bank <= 1'b1;
            end
            if (|(bus.req_valid & ~ready) && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed bench for ram_bank_arbiter with a behavioural multi-bank RAM.
// Expected read responses go into per-requester queues; a monitor pops and
// compares them whenever rsp_valid is seen.
module tb_ram_bank_arbiter;

    localparam int NUM_REQ = 4;
    localparam int RAM_NUM = 10;
    localparam int WIDTH   = 16;
    localparam int ADDRESS = 10;
    localparam int BANK_W  = 4;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic                             clk;
    logic                             rst;
    logic [RAM_NUM-1:0]               ram_en;
    logic [RAM_NUM-1:0]               ram_we;
    logic [RAM_NUM-1:0][ADDRESS-1:0]  ram_addr;
    logic [RAM_NUM-1:0][WIDTH-1:0]    ram_din;
    logic [RAM_NUM-1:0][WIDTH-1:0]    ram_dout;
    logic                             err_bank;
    logic [15:0]                      stall_cnt;

    logic [WIDTH-1:0] mem [RAM_NUM][1024];
    exp_t             expQ [NUM_REQ][$];
    int               cyc;
    int               vectors;
    int               miscompares;
    int               grantSeq [5] = '{0, 1, 2, 3, 0};

    ram_bank_arbiter_if #(
        .NUM_REQ(NUM_REQ), .RAM_NUM(RAM_NUM), .WIDTH(WIDTH),
        .ADDRESS(ADDRESS), .BANK_W(BANK_W)
    ) bus ();

    ram_bank_arbiter #(
        .NUM_REQ(NUM_REQ), .RAM_NUM(RAM_NUM), .WIDTH(WIDTH),
        .ADDRESS(ADDRESS), .BANK_W(BANK_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .err_bank (err_bank),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first synchronous RAM port A, one registered output per bank
    always @(posedge clk) begin
        for (int b = 0; b < RAM_NUM; b++) begin
            if (ram_en[b]) begin
                if (ram_we[b]) mem[b][ram_addr[b]] <= ram_din[b];
                ram_dout[b] <= mem[b][ram_addr[b]];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setReq(input logic [1:0] r, input logic v, input logic we,
                          input logic [3:0] bank, input logic [9:0] addr,
                          input logic [15:0] wdata);
        bus.req_valid[r] = v;
        bus.req_we[r]    = we;
        bus.req_bank[r]  = bank;
        bus.req_addr[r]  = addr;
        bus.req_wdata[r] = wdata;
    endtask

    task automatic clearAll();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_bank  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic pushExp(input int r, input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1;
        expQ[r].push_back(e);
    endtask

    // Scoreboard monitor: every response must match the head of its queue and arrive on time
    always @(negedge clk) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (expQ[r].size() > 0 && expQ[r][0].due < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL missing_rsp_r%0d: got no response, expected %0h at cycle %0d",
                         r, expQ[r][0].data, expQ[r][0].due);
                void'(expQ[r].pop_front());
            end
            if (bus.rsp_valid[r]) begin
                if (expQ[r].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_rsp_r%0d: got %0h, expected no response",
                             r, bus.rsp_data[r]);
                end else begin
                    exp_t e;
                    e = expQ[r].pop_front();
                    checkOutput($sformatf("rsp_data_r%0d", r), 32'(bus.rsp_data[r]), 32'(e.data));
                    checkOutput($sformatf("rsp_cycle_r%0d", r), cyc, e.due);
                end
            end
        end
    end

    // Hard time bound so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus();
        // Reset state, with a request present that must not be granted
        rst = 1'b0;
        clearAll();
        repeat (2) @(negedge clk);
        setReq(0, 1, 0, 3, 5, 0);
        #1;
        checkOutput("reset_ready", 32'(bus.req_ready), 0);
        checkOutput("reset_ram_en", 32'(ram_en), 0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("reset_rsp_data0", 32'(bus.rsp_data[0]), 0);
        checkOutput("reset_stall", 32'(stall_cnt), 0);
        checkOutput("reset_err", 32'(err_bank), 0);
        @(negedge clk);
        clearAll();
        rst = 1'b1;

        // Single read: r0, bank 3, addr 5
        @(negedge clk);
        setReq(0, 1, 0, 3, 5, 0);
        pushExp(0, 16'h00A5);
        #1;
        checkOutput("single_ready", 32'(bus.req_ready), 32'b0001);
        checkOutput("single_ram_en", 32'(ram_en), 32'b0000001000);
        checkOutput("single_addr", 32'(ram_addr[3]), 5);

        // Four-way conflict on bank 2, requests held continuously
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) setReq(2'(r), 1, 0, 2, 10'(10 + r), 0);
            pushExp(grantSeq[k], 16'h200A + 16'(grantSeq[k]));
            #1;
            checkOutput($sformatf("conflict_ready_%0d", k), 32'(bus.req_ready), 32'(1 << grantSeq[k]));
            checkOutput($sformatf("conflict_en_%0d", k), 32'(ram_en), 32'b0000000100);
        end

        // Parallel grants on banks 0, 1 and 9
        @(negedge clk);
        clearAll();
        setReq(0, 1, 0, 0, 7, 0);
        setReq(1, 1, 0, 1, 8, 0);
        setReq(2, 1, 0, 9, 1023, 0);
        pushExp(0, 16'h0007);
        pushExp(1, 16'h1008);
        pushExp(2, 16'h93FF);
        #1;
        checkOutput("conflict_stall", 32'(stall_cnt), 5);
        checkOutput("parallel_ready", 32'(bus.req_ready), 32'b0111);
        checkOutput("parallel_ram_en", 32'(ram_en), 32'b1000000011);
        checkOutput("parallel_addr9", 32'(ram_addr[9]), 1023);

        // Write then read back on bank 4, addr 1023
        @(negedge clk);
        clearAll();
        setReq(1, 1, 1, 4, 1023, 16'hBEEF);
        #1;
        checkOutput("write_ready", 32'(bus.req_ready), 32'b0010);
        checkOutput("write_ram_we", 32'(ram_we), 32'b0000010000);
        checkOutput("write_din", 32'(ram_din[4]), 32'hBEEF);
        @(negedge clk);
        setReq(1, 1, 0, 4, 1023, 0);
        pushExp(1, 16'hBEEF);
        #1;
        checkOutput("readback_ready", 32'(bus.req_ready), 32'b0010);
        checkOutput("readback_ram_we", 32'(ram_we), 0);

        // Out-of-range bank 12
        @(negedge clk);
        clearAll();
        #1;
        checkOutput("err_before_bad", 32'(err_bank), 0);
        setReq(2, 1, 0, 12, 0, 0);
        pushExp(2, 16'h0000);
        #1;
        checkOutput("bad_ready", 32'(bus.req_ready), 32'b0100);
        checkOutput("bad_ram_en", 32'(ram_en), 0);
        @(negedge clk);
        clearAll();
        #1;
        checkOutput("bad_err_set", 32'(err_bank), 1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("bad_err_sticky", 32'(err_bank), 1);
        checkOutput("idle_stall", 32'(stall_cnt), 5);

        // Reset right after a read grant discards the response
        @(negedge clk);
        setReq(3, 1, 0, 5, 2, 0);
        #1;
        checkOutput("pre_reset_ready", 32'(bus.req_ready), 32'b1000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearAll();
        setReq(0, 1, 0, 2, 10, 0);
        #1;
        checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("midreset_err", 32'(err_bank), 0);
        checkOutput("midreset_stall", 32'(stall_cnt), 0);
        checkOutput("midreset_ready", 32'(bus.req_ready), 0);
        checkOutput("midreset_ram_en", 32'(ram_en), 0);
        @(negedge clk);
        clearAll();
        rst = 1'b1;

        // Bank 2 pointer was left at 1; after reset r0 must win over r1
        @(negedge clk);
        setReq(0, 1, 0, 2, 10, 0);
        setReq(1, 1, 0, 2, 11, 0);
        pushExp(0, 16'h200A);
        #1;
        checkOutput("ptr_reset_ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        clearAll();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        for (int b = 0; b < RAM_NUM; b++)
            for (int a = 0; a < 1024; a++)
                mem[b][a] = 16'((b << 12) | a);
        mem[3][5] = 16'h00A5;
        for (int b = 0; b < RAM_NUM; b++) ram_dout[b] = '0;

        applyStimulus();

        for (int r = 0; r < NUM_REQ; r++) begin
            checkOutput($sformatf("drain_r%0d", r), 32'(expQ[r].size()), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
